// File: rtl/mul_rr_sched.sv
// Round-robin scheduler sharing one external 8x8 signed multiplier among NREQ requesters.
// Optional product self-check enabled by defining MUL_RR_SCHED_SELFCHECK_EN (adds o_chk_err).
module mul_rr_sched #(
  parameter int NREQ      = 4,
  parameter int PIPE      = 2,
  parameter int OUT_DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NREQ-1:0]          i_req_valid,
  output logic [NREQ-1:0]          o_req_ready,
  input  logic [NREQ*8-1:0]        i_req_x,
  input  logic [NREQ*8-1:0]        i_req_y,
  output logic [7:0]               o_mul_x,
  output logic [7:0]               o_mul_y,
  input  logic [15:0]              i_mul_p,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [$clog2(NREQ)-1:0]  o_rsp_id,
  output logic [15:0]              o_rsp_p,
`ifdef MUL_RR_SCHED_SELFCHECK_EN
  output logic                     o_chk_err,
`endif
  output logic                     o_busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int QW  = $clog2(OUT_DEPTH);
  localparam int CW  = $clog2(OUT_DEPTH + 1);

  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_idx;
  logic [IDW-1:0] w_ptr_nxt;
  logic [IDW:0]   w_scan;
  logic           w_found;
  logic           w_accept;
  logic           w_pop;
  logic           w_push;
  logic [15:0]    w_push_p;
  logic [IDW-1:0] w_push_id;
  logic           w_pipe_busy;
  logic [7:0]     w_sel_x;
  logic [7:0]     w_sel_y;
  logic [CW-1:0]  r_credits;
  logic           r_v0;
  logic [IDW-1:0] r_id0;
  logic [7:0]     r_mul_x;
  logic [7:0]     r_mul_y;

  logic [15:0]    r_q_p  [OUT_DEPTH];
  logic [IDW-1:0] r_q_id [OUT_DEPTH];
  logic [QW-1:0]  r_wptr;
  logic [QW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;

  function automatic logic [QW-1:0] q_inc(input logic [QW-1:0] p);
    return (p == QW'(OUT_DEPTH - 1)) ? '0 : p + QW'(1);
  endfunction

  // Scan from the RR pointer with wrap; first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_scan  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_scan >= (IDW+1)'(NREQ)) w_scan = w_scan - (IDW+1)'(NREQ);
      if (!w_found && i_req_valid[w_scan[IDW-1:0]]) begin
        w_found = 1'b1;
        w_idx   = w_scan[IDW-1:0];
      end
    end
  end

  always_comb begin
    w_sel_x = '0;
    w_sel_y = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_idx == IDW'(k)) begin
        w_sel_x = i_req_x[8*k +: 8];
        w_sel_y = i_req_y[8*k +: 8];
      end
    end
  end

  assign w_accept    = w_found & (r_credits != '0) & ~i_rst;
  assign o_req_ready = w_accept ? (NREQ'(1) << w_idx) : '0;
  assign w_ptr_nxt   = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + IDW'(1);
  assign w_pop       = o_rsp_valid & i_rsp_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr   <= '0;
      r_v0    <= 1'b0;
      r_id0   <= '0;
      r_mul_x <= '0;
      r_mul_y <= '0;
    end else begin
      r_v0 <= w_accept;
      if (w_accept) begin
        r_ptr   <= w_ptr_nxt;
        r_id0   <= w_idx;
        r_mul_x <= w_sel_x;
        r_mul_y <= w_sel_y;
      end
    end
  end

  assign o_mul_x = r_mul_x;
  assign o_mul_y = r_mul_y;

  // The queue slot itself acts as the last product stage, giving PIPE+1 cycles of latency.
  generate
    if (PIPE == 1) begin : g_direct
      assign w_push      = r_v0;
      assign w_push_p    = i_mul_p;
      assign w_push_id   = r_id0;
      assign w_pipe_busy = 1'b0;
    end else begin : g_stages
      logic           r_sv  [1:PIPE-1];
      logic [15:0]    r_sp  [1:PIPE-1];
      logic [IDW-1:0] r_sid [1:PIPE-1];

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          for (int k = 1; k < PIPE; k++) begin
            r_sv[k]  <= 1'b0;
            r_sp[k]  <= '0;
            r_sid[k] <= '0;
          end
        end else begin
          r_sv[1]  <= r_v0;
          r_sp[1]  <= i_mul_p;
          r_sid[1] <= r_id0;
          for (int k = 2; k < PIPE; k++) begin
            r_sv[k]  <= r_sv[k-1];
            r_sp[k]  <= r_sp[k-1];
            r_sid[k] <= r_sid[k-1];
          end
        end
      end

      always_comb begin
        w_pipe_busy = 1'b0;
        for (int k = 1; k < PIPE; k++) w_pipe_busy = w_pipe_busy | r_sv[k];
      end

      assign w_push    = r_sv[PIPE-1];
      assign w_push_p  = r_sp[PIPE-1];
      assign w_push_id = r_sid[PIPE-1];
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int k = 0; k < OUT_DEPTH; k++) begin
        r_q_p[k]  <= '0;
        r_q_id[k] <= '0;
      end
    end else begin
      if (w_push) begin
        r_q_p[r_wptr]  <= w_push_p;
        r_q_id[r_wptr] <= w_push_id;
        r_wptr         <= q_inc(r_wptr);
      end
      if (w_pop) r_rptr <= q_inc(r_rptr);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  // Credits count free queue slots not yet claimed by in-flight products.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_credits <= CW'(OUT_DEPTH);
    end else if (w_accept && !w_pop) begin
      r_credits <= r_credits - CW'(1);
    end else if (!w_accept && w_pop) begin
      r_credits <= r_credits + CW'(1);
    end
  end

  assign o_rsp_valid = (r_count != '0);
  assign o_rsp_p     = r_q_p[r_rptr];
  assign o_rsp_id    = r_q_id[r_rptr];
  assign o_busy      = r_v0 | w_pipe_busy | (r_count != '0);

`ifdef MUL_RR_SCHED_SELFCHECK_EN
  logic [15:0] w_ref_p;
  assign w_ref_p = $signed({{8{r_mul_x[7]}}, r_mul_x}) * $signed({{8{r_mul_y[7]}}, r_mul_y});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_chk_err <= 1'b0;
    end else if (r_v0 && (i_mul_p != w_ref_p)) begin
      o_chk_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_rr_sched.sv
// Bench for mul_rr_sched: queue-based response model checked every cycle, plus
// directed literal checks; define MUL_RR_SCHED_SELFCHECK_EN to exercise o_chk_err.
module tb_mul_rr_sched;
  localparam int NREQ      = 4;
  localparam int PIPE      = 2;
  localparam int OUT_DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  reqValid = '0;
  logic [3:0]  reqReady;
  logic [31:0] reqX = '0;
  logic [31:0] reqY = '0;
  logic [7:0]  mulX;
  logic [7:0]  mulY;
  logic [15:0] mulP;
  logic        rspValid;
  logic        rspReady = 1'b0;
  logic [1:0]  rspId;
  logic [15:0] rspP;
  logic        busy;
  logic        flipBit = 1'b0;
  logic        injectPending = 1'b0;
`ifdef MUL_RR_SCHED_SELFCHECK_EN
  logic        chkErr;
`endif

  int testsRun = 0;
  int testsFailed = 0;
  int cyc = 0;
  int mPtr = 0;
  int mulProd;

  typedef struct {
    int          id;
    logic [15:0] p;
    int          due;
  } rsp_t;
  rsp_t expQ[$];

  always #5 clock = ~clock;

  // The shared multiplier lives outside the scheduler.
  always_comb begin
    mulProd = int'($signed(mulX)) * int'($signed(mulY));
    mulP    = mulProd[15:0] ^ {15'b0, flipBit};
  end

  mul_rr_sched #(.NREQ(NREQ), .PIPE(PIPE), .OUT_DEPTH(OUT_DEPTH)) dut (
    .i_clk       (clock),
    .i_rst       (reset),
    .i_req_valid (reqValid),
    .o_req_ready (reqReady),
    .i_req_x     (reqX),
    .i_req_y     (reqY),
    .o_mul_x     (mulX),
    .o_mul_y     (mulY),
    .i_mul_p     (mulP),
    .o_rsp_valid (rspValid),
    .i_rsp_ready (rspReady),
    .o_rsp_id    (rspId),
    .o_rsp_p     (rspP),
`ifdef MUL_RR_SCHED_SELFCHECK_EN
    .o_chk_err   (chkErr),
`endif
    .o_busy      (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [31:0] x, input logic [31:0] y, input logic r);
    @(posedge clock);
    #1;
    reqValid = v;
    reqX     = x;
    reqY     = y;
    rspReady = r;
    @(negedge clock);
  endtask

  function automatic logic [31:0] pack4(input int a0, input int a1, input int a2, input int a3);
    logic [31:0] packed4;
    packed4 = {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    return packed4;
  endfunction

  // Reference: outstanding products in accept order, each visible PIPE+1 cycles after accept.
  int          mWin;
  int          mCredits;
  int          mIdx;
  int          mProd;
  logic [3:0]  mReady;
  logic        mHead;
  logic signed [7:0] mXs;
  logic signed [7:0] mYs;
  rsp_t        mItem;

  always @(negedge clock) begin : model
    if (reset) begin
      checkOutput("rst_req_ready", reqReady, 0);
      checkOutput("rst_rsp_valid", rspValid, 0);
      checkOutput("rst_rsp_id", rspId, 0);
      checkOutput("rst_rsp_p", rspP, 0);
      checkOutput("rst_busy", busy, 0);
      expQ.delete();
      mPtr = 0;
    end else begin
      mCredits = OUT_DEPTH - expQ.size();
      mWin = -1;
      if (mCredits > 0) begin
        for (int k = 0; k < NREQ; k++) begin
          mIdx = (mPtr + k) % NREQ;
          if (mWin < 0 && reqValid[mIdx]) mWin = mIdx;
        end
      end
      mReady = (mWin >= 0) ? 4'(1 << mWin) : 4'b0;
      checkOutput("req_ready", reqReady, mReady);
      mHead = (expQ.size() > 0) && (expQ[0].due <= cyc);
      checkOutput("rsp_valid", rspValid, mHead);
      if (mHead) begin
        checkOutput("rsp_id", rspId, expQ[0].id);
        checkOutput("rsp_p", rspP, expQ[0].p);
      end
      checkOutput("busy", busy, expQ.size() > 0);
      if (mHead && rspReady) void'(expQ.pop_front());
      if (mWin >= 0) begin
        mXs   = reqX[8*mWin +: 8];
        mYs   = reqY[8*mWin +: 8];
        mProd = int'(mXs) * int'(mYs);
        mItem.id  = mWin;
        mItem.p   = mProd[15:0] ^ {15'b0, injectPending};
        mItem.due = cyc + PIPE + 1;
        expQ.push_back(mItem);
        injectPending = 1'b0;
        mPtr = (mWin + 1) % NREQ;
      end
    end
    cyc++;
  end

  int rrOrder[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
  int rrSkip[6]   = '{0, 1, 3, 0, 1, 3};
  int cornerX[4]  = '{-128, -128, 0, -1};
  int cornerY[4]  = '{-128, 127, -1, -1};
  logic [15:0] cornerP[4] = '{16'h4000, 16'hC080, 16'h0000, 16'h0001};
  logic [15:0] gotP[4];
  int nGot;
  int accepts;
  int extra;

  initial begin
    reqValid = 4'hF;
    repeat (3) @(negedge clock);
    checkOutput("reset_req_ready", reqReady, 0);
    checkOutput("reset_mul_x", mulX, 0);
    checkOutput("reset_mul_y", mulY, 0);
    checkOutput("reset_rsp_p", rspP, 0);
    checkOutput("reset_busy", busy, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    reqValid = '0;
    @(negedge clock);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'hF, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1);
      checkOutput("rr_grant", reqReady, 32'(1 << rrOrder[i]));
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'b1011, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1);
      checkOutput("rr_skip_grant", reqReady, 32'(1 << rrSkip[i]));
    end
    repeat (6) applyStimulus(4'h0, '0, '0, 1'b1);

    applyStimulus(4'b0010, pack4(0, 7, 0, 0), pack4(0, -3, 0, 0), 1'b1);
    checkOutput("single_grant", reqReady, 4'b0010);
    applyStimulus(4'h0, '0, '0, 1'b1);
    applyStimulus(4'h0, '0, '0, 1'b1);
    checkOutput("single_early", rspValid, 0);
    applyStimulus(4'h0, '0, '0, 1'b1);
    checkOutput("single_valid", rspValid, 1);
    checkOutput("single_id", rspId, 1);
    checkOutput("single_p", rspP, 16'hFFEB);

    nGot = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 4) applyStimulus(4'b0001, pack4(cornerX[c], 0, 0, 0), pack4(cornerY[c], 0, 0, 0), 1'b1);
      else       applyStimulus(4'h0, '0, '0, 1'b1);
      if (rspValid && nGot < 4) begin
        gotP[nGot] = rspP;
        nGot++;
      end
    end
    checkOutput("corner_count", nGot, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < nGot) checkOutput("corner_p", gotP[i], cornerP[i]);
    end

    accepts = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'hF, pack4(2, 3, 4, 5), pack4(-1, -2, -3, -4), 1'b0);
      if (reqReady != 0) accepts++;
      if (rspValid) begin
        checkOutput("bp_head_id", rspId, 1);
        checkOutput("bp_head_p", rspP, 16'hFFFA);
      end
    end
    checkOutput("bp_accepts", accepts, 4);
    checkOutput("bp_stalled", reqReady, 0);
    extra = 0;
    applyStimulus(4'hF, pack4(2, 3, 4, 5), pack4(-1, -2, -3, -4), 1'b1);
    if (reqReady != 0) extra++;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4'hF, pack4(2, 3, 4, 5), pack4(-1, -2, -3, -4), 1'b0);
      if (reqReady != 0) extra++;
    end
    checkOutput("bp_one_more", extra, 1);
    checkOutput("bp_next_id", rspId, 2);
    checkOutput("bp_next_p", rspP, 16'hFFF4);
    repeat (12) applyStimulus(4'h0, '0, '0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), $urandom, $urandom, ($urandom_range(0, 3) != 0));
    end
    repeat (10) applyStimulus(4'h0, '0, '0, 1'b1);
    checkOutput("idle_busy", busy, 0);

    repeat (3) applyStimulus(4'b0010, pack4(0, 9, 0, 0), pack4(0, -7, 0, 0), 1'b0);
    applyStimulus(4'h0, '0, '0, 1'b0);
    checkOutput("busy_before_reset", busy, 1);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_rsp_valid", rspValid, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_rsp_p", rspP, 0);
    checkOutput("midrst_rsp_id", rspId, 0);
    checkOutput("midrst_mul_x", mulX, 0);
    checkOutput("midrst_mul_y", mulY, 0);
    @(posedge clock);
    #3;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'h0, '0, '0, 1'b1);
      checkOutput("no_stale_rsp", rspValid, 0);
    end
    applyStimulus(4'hF, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 1'b1);
    checkOutput("ptr_after_reset", reqReady, 4'b0001);
    repeat (6) applyStimulus(4'h0, '0, '0, 1'b1);

`ifdef MUL_RR_SCHED_SELFCHECK_EN
    checkOutput("chk_err_clean", chkErr, 0);
    injectPending = 1'b1;
    applyStimulus(4'b0001, pack4(5, 0, 0, 0), pack4(6, 0, 0, 0), 1'b1);
    @(posedge clock);
    #1;
    flipBit  = 1'b1;
    reqValid = '0;
    @(negedge clock);
    @(posedge clock);
    #1;
    flipBit = 1'b0;
    @(negedge clock);
    checkOutput("chk_err_set", chkErr, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'h0, '0, '0, 1'b1);
      checkOutput("chk_err_sticky", chkErr, 1);
    end
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("chk_err_cleared", chkErr, 0);
    @(posedge clock);
    #3;
    reset = 1'b0;
    @(negedge clock);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
